// File: rtl/seq_multiplier_4bit.sv
// Unsigned 4x4 -> 8-bit shift-and-add multiplier with a start/busy/done handshake.
// A single 4-bit ripple-carry adder performs one partial-product add per CALC cycle.

module full_adder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    always_comb begin
        logic carry;
        carry = cin_i;
        sum_o = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end
endmodule

module seq_multiplier_4bit #(
    parameter int unsigned ZERO_BYPASS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] op_a,
    input  logic [3:0] op_b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] mcand_q, mcand_d;
    logic [3:0] acc_hi_q, acc_hi_d;
    logic [3:0] mplier_q, mplier_d;
    logic [1:0] count_q, count_d;
    logic [7:0] product_q, product_d;

    logic [3:0] add_b;
    logic [3:0] add_sum;
    logic       add_cout;
    logic [7:0] shifted;

    assign add_b   = mplier_q[0] ? mcand_q : 4'h0;
    assign shifted = {add_cout, add_sum, mplier_q[3:1]};

    full_adder_4bit u_adder (
        .a_i    (acc_hi_q),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_hi_d = '0;
                    count_d  = '0;
                    if ((ZERO_BYPASS != 0) && ((op_a == 4'h0) || (op_b == 4'h0))) begin
                        product_d = '0;
                        state_d   = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // Carry-out enters acc_hi MSB so the final bit 7 is never lost.
                {acc_hi_d, mplier_d} = shifted;
                count_d              = count_q + 2'd1;
                if (count_q == 2'd3) begin
                    product_d = shifted;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == CALC);
        done    = (state_q == DONE);
        product = product_q;
    end
endmodule

// File: tb/tb_seq_multiplier_4bit.sv
// Scoreboard bench for seq_multiplier_4bit: stimulus pushes expected product/cycle,
// a negedge monitor pops and compares on every done pulse.

module tb_seq_multiplier_4bit;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       start_nb;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       busy, done;
    logic [7:0] product;
    logic       busy_nb, done_nb;
    logic [7:0] product_nb;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] prod;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_multiplier_4bit #(.ZERO_BYPASS(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    seq_multiplier_4bit #(.ZERO_BYPASS(0)) dut_nb (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start_nb),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy_nb),
        .done    (done_nb),
        .product (product_nb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p, input int lat);
        exp_t e;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        e.prod = p;
        e.cyc  = cyc + lat;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 product=0x%0h at cycle %0d, expected no done", product, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", {24'h0, product}, {24'h0, e.prod});
                check("done_cycle", cyc, e.cyc);
                check("busy_in_done", {31'h0, busy}, 32'h0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        int n;
        reset_n  = 1'b0;
        start    = 1'b0;
        start_nb = 1'b0;
        op_a     = 4'h0;
        op_b     = 4'h0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_product", {24'h0, product}, 32'h0);
        check("reset_product_nb", {24'h0, product_nb}, 32'h0);

        // 15 x 15: busy for four cycles, done in cycle 5
        issue(4'hF, 4'hF, 8'hE1, 5);
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check("busy_calc", {31'h0, busy}, 32'h1);
            check("done_calc", {31'h0, done}, 32'h0);
            tick();
        end
        check("busy_after_calc", {31'h0, busy}, 32'h0);
        check("done_c5", {31'h0, done}, 32'h1);
        tick();

        // Zero operand: bypass finishes in one cycle, non-bypass in five
        issue(4'h9, 4'h0, 8'h00, 1);
        tick();
        start = 1'b0;
        tick();
        start_nb = 1'b1;
        c = cyc;
        tick();
        start_nb = 1'b0;
        n = 0;
        while (done_nb !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("nb_done", {31'h0, done_nb}, 32'h1);
        check("nb_latency", cyc - c, 5);
        check("nb_product", {24'h0, product_nb}, 32'h0);
        tick();

        // Start during CALC is ignored
        issue(4'h3, 4'h5, 8'h0F, 5);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        op_a  = 4'h2;
        op_b  = 4'h2;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("sb_empty_after_ignore", sb.size(), 0);

        // Back-to-back: second start accepted in DONE
        issue(4'h3, 4'h5, 8'h0F, 5);
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("b2b_first_done", {31'h0, done}, 32'h1);
        issue(4'h7, 4'h6, 8'h2A, 5);
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("sb_empty_after_b2b", sb.size(), 0);

        // Asynchronous reset mid-CALC aborts the operation
        issue(4'hA, 4'hB, 8'h6E, 5);
        tick();
        start = 1'b0;
        repeat (2) tick();
        #2;
        reset_n = 1'b0;
        sb.delete(sb.size() - 1);
        #1;
        check("async_rst_busy", {31'h0, busy}, 32'h0);
        check("async_rst_done", {31'h0, done}, 32'h0);
        check("async_rst_product", {24'h0, product}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) tick();
        check("no_done_after_abort", {24'h0, product}, 32'h0);

        // All operand pairs against a*b
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int lat;
                lat = (a == 0 || b == 0) ? 1 : 5;
                issue(4'(a), 4'(b), 8'(a * b), lat);
                tick();
                start = 1'b0;
                repeat (lat) tick();
            end
        end

        repeat (3) tick();
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_done: got no done, expected product 0x%0h at cycle %0d", e.prod, e.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
